div5b_seq: RTL

Sequential 5-bit unsigned restoring divider, the inverse operation of the 5-bit array multiplier row. It takes a dividend and a divisor on a start pulse, produces one quotient bit per clock MSB-first, and returns quotient and remainder with a one-cycle done pulse. It is the arithmetic back end for FPGA demos that already use the 5-bit multiplier. Operands arrive from switches or registers; results go to displays or downstream logic.

---
 rtl/div5b_seq_pkg.sv | 13 +
 rtl/bloque_div5b.sv | 29 ++
 rtl/div5b_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/div5b_seq_pkg.sv
// Shared definitions for the 5-bit sequential restoring divider:
// FSM state encoding and the default operand width.
package div5b_seq_pkg;

  localparam int DEF_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/bloque_div5b.sv
// One combinational restoring-division row: trial subtract of the divisor from
// the shifted partial remainder using a chain of full-subtractor cells.
module bloque_div5b #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] brw;

  assign b_ext  = {1'b0, b_i};
  assign brw[0] = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fs
    assign diff[i]  = a_i[i] ^ b_ext[i] ^ brw[i];
    assign brw[i+1] = (~a_i[i] & b_ext[i]) | (~(a_i[i] ^ b_ext[i]) & brw[i]);
  end

  // A set top difference bit can only accompany a borrow; folding it in keeps
  // the kept remainder guaranteed to fit WIDTH bits.
  assign qbit_o = ~(brw[WIDTH+1] | diff[WIDTH]);
  assign rem_o  = qbit_o ? diff[WIDTH-1:0] : a_i[WIDTH-1:0];

endmodule

// File: rtl/div5b_seq.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, MSB first,
// with a one-cycle done pulse and a divide-by-zero flag.
module div5b_seq
  import div5b_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             div0_q, div0_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] row_rem;
  logic             row_qbit;

  // quo_q starts as the dividend and fills with quotient bits as it shifts out
  bloque_div5b #(.WIDTH(WIDTH)) u_row (
    .a_i    ({rem_q, quo_q[WIDTH-1]}),
    .b_i    (dvs_q),
    .rem_o  (row_rem),
    .qbit_o (row_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvs_d  = Y;
          div0_d = (Y == '0);
          if (Y == '0) begin
            quo_d   = '1;
            rem_d   = X;
            state_d = ST_FIN;
          end else begin
            quo_d   = X;
            rem_d   = '0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        rem_d = row_rem;
        quo_d = {quo_q[WIDTH-2:0], row_qbit};
        if (cnt_q == '0) state_d = ST_FIN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FIN: begin
        q_d     = quo_q;
        r_d     = rem_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
    end
  end

  // Working registers need no reset: they are reloaded on every accepted start
  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    quo_q <= quo_d;
    dvs_q <= dvs_d;
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign div0 = div0_q;

endmodule
